// File: rtl/bp_be_late_wb_arbiter_pkg.sv
// Shared types for the late writeback arbiter: the writeback packet layout
// and a small round-robin helper.
package bp_be_late_wb_arbiter_pkg;

  localparam int dword_width_gp    = 64;
  localparam int reg_addr_width_gp = 5;
  localparam int fflags_width_gp   = 5;

  typedef struct packed {
    logic                         ird_w_v;
    logic                         frd_w_v;
    logic [reg_addr_width_gp-1:0] rd_addr;
    logic [dword_width_gp-1:0]    rd_data;
    logic                         fflags_w_v;
    logic [fflags_width_gp-1:0]   fflags;
  } bp_be_wb_pkt_s;

  localparam int wb_pkt_width_lp = $bits(bp_be_wb_pkt_s);

  // Successor of idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bp_be_late_wb_arbiter_if.sv
// Producer-side and scheduler-side handshake bundle of the late writeback arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface bp_be_late_wb_arbiter_if
  import bp_be_late_wb_arbiter_pkg::*;
#(
  parameter int num_req_p = 2
) ();

  bp_be_wb_pkt_s [num_req_p-1:0] req_wb_pkt_i;
  logic          [num_req_p-1:0] req_v_i;
  logic          [num_req_p-1:0] req_ready_and_o;
  logic                          inject_busy_i;
  bp_be_wb_pkt_s                 late_wb_pkt_o;
  logic                          late_wb_v_o;
  logic                          late_wb_force_o;
  logic                          late_wb_yumi_i;

  modport master (
    output req_wb_pkt_i, req_v_i, inject_busy_i, late_wb_yumi_i,
    input  req_ready_and_o, late_wb_pkt_o, late_wb_v_o, late_wb_force_o
  );

  modport slave (
    input  req_wb_pkt_i, req_v_i, inject_busy_i, late_wb_yumi_i,
    output req_ready_and_o, late_wb_pkt_o, late_wb_v_o, late_wb_force_o
  );

endinterface

// File: rtl/bp_be_late_wb_fifo.sv
// Small 1r1w FIFO with ready_and/valid input and valid/yumi output.
// Readiness depends only on occupancy; a new entry shows at the head one cycle later.
module bp_be_late_wb_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] i_data,
  input  logic               i_v,
  output logic               o_ready_and,
  output logic [width_p-1:0] o_data,
  output logic               o_v,
  input  logic               i_yumi
);

  localparam int ptr_width_lp = $clog2(els_p);

  logic [width_p-1:0]    r_mem [els_p];
  logic [ptr_width_lp:0] r_wptr;
  logic [ptr_width_lp:0] r_rptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_enq;
  logic                  w_deq;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ptr_width_lp] != r_rptr[ptr_width_lp])
                && (r_wptr[ptr_width_lp-1:0] == r_rptr[ptr_width_lp-1:0]);

  assign o_ready_and = !w_full;
  assign o_v         = !w_empty;
  assign o_data      = r_mem[r_rptr[ptr_width_lp-1:0]];

  assign w_enq = i_v & !w_full;
  assign w_deq = i_yumi & !w_empty;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + (ptr_width_lp+1)'(1);
      if (w_deq) r_rptr <= r_rptr + (ptr_width_lp+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr[ptr_width_lp-1:0]] <= i_data;
  end

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Buffers late writebacks per producer and offers one at a time to the scheduler's
// injection slot, round-robin, with a starvation escape that forces injection.
module bp_be_late_wb_arbiter
  import bp_be_late_wb_arbiter_pkg::*;
#(
  parameter  int num_req_p           = 2,
  parameter  int fifo_els_p          = 2,
  parameter  int starve_limit_p      = 16,
  localparam int starve_cnt_width_lp = $clog2(starve_limit_p+1)
) (
  input logic                    clk_i,
  input logic                    reset_i,
  bp_be_late_wb_arbiter_if.slave wb_if
);

  localparam int idx_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  typedef logic [idx_width_lp-1:0] idx_t;

  logic          [num_req_p-1:0] w_ready;
  logic          [num_req_p-1:0] w_nonempty;
  logic          [num_req_p-1:0] w_deq;
  bp_be_wb_pkt_s [num_req_p-1:0] w_head;

  idx_t                           r_rr_ptr;
  logic                           r_grant_lock;
  idx_t                           r_grant_idx;
  logic [starve_cnt_width_lp-1:0] r_starve_cnt;

  idx_t w_sel;
  logic w_pending;
  logic w_force;
  logic w_v;
  logic w_accept;

  for (genvar g = 0; g < num_req_p; g++) begin : g_fifo
    bp_be_late_wb_fifo #(
      .width_p (wb_pkt_width_lp),
      .els_p   (fifo_els_p)
    ) u_fifo (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .i_data      (wb_if.req_wb_pkt_i[g]),
      .i_v         (wb_if.req_v_i[g]),
      .o_ready_and (w_ready[g]),
      .o_data      (w_head[g]),
      .o_v         (w_nonempty[g]),
      .i_yumi      (w_deq[g])
    );
    assign w_deq[g] = w_accept & (w_sel == idx_t'(g));
  end

  // Once a packet has been offered and not taken, keep offering the same producer.
  always_comb begin
    idx_t v_idx;
    logic v_found;
    w_sel   = r_rr_ptr;
    v_found = 1'b0;
    v_idx   = '0;
    if (r_grant_lock) begin
      w_sel = r_grant_idx;
    end else begin
      for (int k = 0; k < num_req_p; k++) begin
        v_idx = idx_t'((int'(r_rr_ptr) + k) % num_req_p);
        if (!v_found && w_nonempty[v_idx]) begin
          v_found = 1'b1;
          w_sel   = v_idx;
        end
      end
    end
  end

  assign w_pending = |w_nonempty;
  assign w_force   = !reset_i & w_pending
                   & (r_starve_cnt == starve_cnt_width_lp'(starve_limit_p));
  assign w_v       = !reset_i & w_pending & (!wb_if.inject_busy_i | w_force);
  assign w_accept  = w_v & wb_if.late_wb_yumi_i;

  assign wb_if.req_ready_and_o = reset_i ? '0 : w_ready;
  assign wb_if.late_wb_v_o     = w_v;
  assign wb_if.late_wb_force_o = w_force;
  assign wb_if.late_wb_pkt_o   = w_v ? w_head[w_sel] : '0;

  // Accept releases the lock and moves priority past the winner; the starvation
  // count runs only while something waits without being taken.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rr_ptr     <= '0;
      r_grant_lock <= 1'b0;
      r_grant_idx  <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_grant_lock <= 1'b0;
        r_rr_ptr     <= idx_t'(rr_next(int'(w_sel), num_req_p));
      end else if (w_v) begin
        r_grant_lock <= 1'b1;
        r_grant_idx  <= w_sel;
      end
      if (w_accept || !w_pending) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != starve_cnt_width_lp'(starve_limit_p)) begin
        r_starve_cnt <= r_starve_cnt + starve_cnt_width_lp'(1);
      end
    end
  end

  a_yumi_only_with_v: assert property (@(posedge clk_i) disable iff (reset_i)
    wb_if.late_wb_yumi_i |-> w_v);

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Randomized and directed bench for the late writeback arbiter; a queue-based
// reference model predicts ready, offer, force and packet every cycle.
module tb_bp_be_late_wb_arbiter;
  import bp_be_late_wb_arbiter_pkg::*;

  localparam int NumReq      = 3;
  localparam int FifoEls     = 2;
  localparam int StarveLimit = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bp_be_late_wb_arbiter_if #(.num_req_p(NumReq)) wbIf ();

  bp_be_late_wb_arbiter #(
    .num_req_p      (NumReq),
    .fifo_els_p     (FifoEls),
    .starve_limit_p (StarveLimit)
  ) dut (
    .clk_i   (clock),
    .reset_i (reset),
    .wb_if   (wbIf.slave)
  );

  int total = 0;
  int bad = 0;
  int enqCount = 0;
  int discardCount = 0;
  int dutAccepts = 0;

  logic                       sV;
  logic                       sF;
  bp_be_wb_pkt_s              sPkt;
  logic [NumReq-1:0]          sReady;
  bp_be_wb_pkt_s [NumReq-1:0] pk;

  bp_be_wb_pkt_s modelQ [NumReq][$];

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  function automatic bp_be_wb_pkt_s makePkt(input logic [4:0] rdAddr);
    bp_be_wb_pkt_s p;
    p.ird_w_v    = 1'($urandom_range(0, 1));
    p.frd_w_v    = 1'($urandom_range(0, 1));
    p.rd_addr    = rdAddr;
    p.rd_data    = {$urandom(), $urandom()};
    p.fflags_w_v = 1'($urandom_range(0, 1));
    p.fflags     = 5'($urandom_range(0, 31));
    return p;
  endfunction

  function automatic bp_be_wb_pkt_s [NumReq-1:0] randPkts();
    bp_be_wb_pkt_s [NumReq-1:0] r;
    for (int i = 0; i < NumReq; i++) r[i] = makePkt(5'($urandom_range(0, 31)));
    return r;
  endfunction

  function automatic bit modelHasData();
    for (int i = 0; i < NumReq; i++) if (modelQ[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive inputs after the falling edge, take the offer if wanted.
  task automatic applyStimulus(input logic rst, input logic [NumReq-1:0] reqV,
                               input bp_be_wb_pkt_s [NumReq-1:0] pkts,
                               input logic busy, input logic wish);
    @(negedge clock);
    reset                = rst;
    wbIf.req_v_i         = reqV;
    wbIf.req_wb_pkt_i    = pkts;
    wbIf.inject_busy_i   = busy;
    wbIf.late_wb_yumi_i  = 1'b0;
    #1;
    wbIf.late_wb_yumi_i = wbIf.late_wb_v_o & wish;
    sV     = wbIf.late_wb_v_o;
    sF     = wbIf.late_wb_force_o;
    sPkt   = wbIf.late_wb_pkt_o;
    sReady = wbIf.req_ready_and_o;
    if (wbIf.late_wb_v_o & wish) dutAccepts++;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, '0, pk, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, pk, 1'b0, 1'b0);
  endtask

  // Reference model: per-producer queues, rotating priority and a wait counter.
  initial begin
    int rr = 0;
    int lockIdx = 0;
    int starve = 0;
    bit lockOn = 1'b0;
    forever begin
      bit pending;
      bit expV;
      bit expForce;
      int sel;
      logic [NumReq-1:0] expReady;
      bp_be_wb_pkt_s expPkt;
      @(negedge clock);
      #2;
      if (reset) begin
        checkOutput("rst_v", wbIf.late_wb_v_o, 0);
        checkOutput("rst_force", wbIf.late_wb_force_o, 0);
        checkOutput("rst_ready", wbIf.req_ready_and_o, 0);
        checkOutput("rst_pkt", wbIf.late_wb_pkt_o, 0);
        for (int i = 0; i < NumReq; i++) begin
          discardCount += modelQ[i].size();
          modelQ[i].delete();
        end
        rr = 0;
        lockOn = 1'b0;
        starve = 0;
      end else begin
        pending = modelHasData();
        sel = rr;
        if (lockOn) sel = lockIdx;
        else begin
          for (int k = NumReq - 1; k >= 0; k--)
            if (modelQ[(rr + k) % NumReq].size() != 0) sel = (rr + k) % NumReq;
        end
        expForce = pending && (starve == StarveLimit);
        expV = pending && (!wbIf.inject_busy_i || expForce);
        for (int i = 0; i < NumReq; i++) expReady[i] = (modelQ[i].size() < FifoEls);
        expPkt = expV ? modelQ[sel][0] : '0;
        checkOutput("ready", wbIf.req_ready_and_o, expReady);
        checkOutput("v", wbIf.late_wb_v_o, expV);
        checkOutput("force", wbIf.late_wb_force_o, expForce);
        checkOutput("pkt", wbIf.late_wb_pkt_o, expPkt);
        if (expV && wbIf.late_wb_yumi_i) begin
          void'(modelQ[sel].pop_front());
          rr = (sel + 1) % NumReq;
          lockOn = 1'b0;
          starve = 0;
        end else begin
          if (expV) begin
            lockOn = 1'b1;
            lockIdx = sel;
          end
          if (!pending) starve = 0;
          else if (starve < StarveLimit) starve++;
        end
        for (int i = 0; i < NumReq; i++) begin
          if (wbIf.req_v_i[i] && expReady[i]) begin
            modelQ[i].push_back(wbIf.req_wb_pkt_i[i]);
            enqCount++;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] order [$];
    int firstV;
    logic forceAtFirst;
    int burstLeft;

    wbIf.req_v_i        = '0;
    wbIf.req_wb_pkt_i   = '0;
    wbIf.inject_busy_i  = 1'b0;
    wbIf.late_wb_yumi_i = 1'b0;
    pk = randPkts();
    doReset();

    // Single entry: offered the cycle after enqueue, then gone.
    pk = randPkts();
    pk[0] = makePkt(5'd5);
    applyStimulus(1'b0, NumReq'(1), pk, 1'b0, 1'b1);
    checkOutput("t1_no_bypass", sV, 0);
    applyStimulus(1'b0, '0, pk, 1'b0, 1'b1);
    checkOutput("t1_v", sV, 1);
    checkOutput("t1_rd_addr", sPkt.rd_addr, 5);
    checkOutput("t1_force", sF, 0);
    applyStimulus(1'b0, '0, pk, 1'b0, 1'b1);
    checkOutput("t1_empty_after", sV, 0);

    // Two producers with two packets each drain in rotating order.
    doReset();
    pk[0] = makePkt(5'd1);
    pk[1] = makePkt(5'd3);
    applyStimulus(1'b0, NumReq'(3), pk, 1'b0, 1'b1);
    pk[0] = makePkt(5'd2);
    pk[1] = makePkt(5'd4);
    applyStimulus(1'b0, NumReq'(3), pk, 1'b0, 1'b1);
    if (sV) order.push_back(sPkt.rd_addr);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, '0, pk, 1'b0, 1'b1);
      if (sV) order.push_back(sPkt.rd_addr);
    end
    checkOutput("t2_count", order.size(), 4);
    if (order.size() == 4) begin
      checkOutput("t2_order0", order[0], 1);
      checkOutput("t2_order1", order[1], 3);
      checkOutput("t2_order2", order[2], 2);
      checkOutput("t2_order3", order[3], 4);
    end

    // A full FIFO refuses even while being dequeued; accepts the next cycle.
    doReset();
    pk[0] = makePkt(5'd7);
    applyStimulus(1'b0, NumReq'(1), pk, 1'b1, 1'b0);
    pk[0] = makePkt(5'd8);
    applyStimulus(1'b0, NumReq'(1), pk, 1'b1, 1'b0);
    pk[0] = makePkt(5'd9);
    applyStimulus(1'b0, NumReq'(1), pk, 1'b0, 1'b1);
    checkOutput("t3_full_ready", sReady[0], 0);
    checkOutput("t3_head0", sPkt.rd_addr, 7);
    applyStimulus(1'b0, NumReq'(1), pk, 1'b0, 1'b1);
    checkOutput("t3_ready_after", sReady[0], 1);
    checkOutput("t3_head1", sPkt.rd_addr, 8);
    applyStimulus(1'b0, '0, pk, 1'b0, 1'b1);
    checkOutput("t3_third_v", sV, 1);
    checkOutput("t3_third", sPkt.rd_addr, 9);

    // Busy slot for 20 cycles: force rises on the 17th waiting cycle.
    doReset();
    pk[0] = makePkt(5'd11);
    applyStimulus(1'b0, NumReq'(1), pk, 1'b1, 1'b1);
    firstV = 0;
    forceAtFirst = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      applyStimulus(1'b0, '0, pk, 1'b1, 1'b1);
      if (sV && firstV == 0) begin
        firstV = j;
        forceAtFirst = sF;
      end
    end
    checkOutput("t4_first_offer_cycle", firstV, 17);
    checkOutput("t4_forced", forceAtFirst, 1);
    checkOutput("t4_force_cleared", sF, 0);

    // Locked offer stays on producer 1 while producer 0 waits.
    doReset();
    pk[1] = makePkt(5'd13);
    applyStimulus(1'b0, NumReq'(2), pk, 1'b0, 1'b0);
    pk[0] = makePkt(5'd14);
    applyStimulus(1'b0, NumReq'(1), pk, 1'b0, 1'b0);
    checkOutput("t5_lock0", sPkt.rd_addr, 13);
    applyStimulus(1'b0, '0, pk, 1'b1, 1'b0);
    checkOutput("t5_busy_v", sV, 0);
    applyStimulus(1'b0, '0, pk, 1'b0, 1'b0);
    checkOutput("t5_lock2", sPkt.rd_addr, 13);
    applyStimulus(1'b0, '0, pk, 1'b0, 1'b1);
    checkOutput("t5_accept", sPkt.rd_addr, 13);
    applyStimulus(1'b0, '0, pk, 1'b0, 1'b1);
    checkOutput("t5_next_v", sV, 1);
    checkOutput("t5_next", sPkt.rd_addr, 14);

    // Reset with buffered entries discards them.
    doReset();
    pk = randPkts();
    applyStimulus(1'b0, NumReq'(3), pk, 1'b1, 1'b0);
    pk = randPkts();
    applyStimulus(1'b0, NumReq'(1), pk, 1'b1, 1'b0);
    applyStimulus(1'b1, '0, pk, 1'b0, 1'b1);
    checkOutput("t6_rst_v", sV, 0);
    checkOutput("t6_rst_force", sF, 0);
    checkOutput("t6_rst_ready", sReady, 0);
    applyStimulus(1'b0, '0, pk, 1'b0, 1'b1);
    checkOutput("t6_post_v", sV, 0);
    checkOutput("t6_post_ready", sReady, {NumReq{1'b1}});

    // Random traffic with busy bursts and occasional resets.
    burstLeft = 0;
    for (int c = 0; c < 3000; c++) begin
      logic rst;
      logic busy;
      logic wish;
      logic [NumReq-1:0] rv;
      rst = ($urandom_range(0, 999) < 3);
      if (burstLeft > 0) begin
        busy = 1'b1;
        burstLeft--;
      end else begin
        if ($urandom_range(0, 99) < 3) burstLeft = $urandom_range(10, 30);
        busy = ($urandom_range(0, 99) < 25);
      end
      wish = ($urandom_range(0, 99) < 60);
      for (int i = 0; i < NumReq; i++) rv[i] = ($urandom_range(0, 99) < 45);
      pk = randPkts();
      applyStimulus(rst, rv, pk, busy, wish);
    end

    for (int c = 0; c < 100 && modelHasData(); c++) begin
      applyStimulus(1'b0, '0, pk, 1'b0, 1'b1);
      #2;
    end
    applyStimulus(1'b0, '0, pk, 1'b0, 1'b1);
    checkOutput("drain_idle_v", sV, 0);
    applyStimulus(1'b0, '0, pk, 1'b0, 1'b1);
    #3;
    checkOutput("drain_accounting", dutAccepts, enqCount - discardCount);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
